// File: rtl/cyc74_dec_sched_if.sv
// +--------------------------------------------------------------------------+
// | cyc74_dec_sched_if : requester/sink handshake bundle for cyc74_dec_sched  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface cyc74_dec_sched_if;
   logic       in0_valid;
   logic [6:0] in0_code;
   logic       in0_ready;
   logic       in1_valid;
   logic [6:0] in1_code;
   logic       in1_ready;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] out_code;
   logic [3:0] out_data;
   logic       out_id;
   logic       out_err;

   modport slave (
      input  in0_valid, in0_code, in1_valid, in1_code, out_ready,
      output in0_ready, in1_ready, out_valid, out_code, out_data, out_id, out_err
   );

   modport master (
      output in0_valid, in0_code, in1_valid, in1_code, out_ready,
      input  in0_ready, in1_ready, out_valid, out_code, out_data, out_id, out_err
   );
endinterface

`default_nettype wire

// File: rtl/cyc74_dec_sched.sv
// +--------------------------------------------------------------------------+
// | cyc74_dec_sched : round-robin scheduler + Meggitt (7,4) cyclic decoder    |
// | Optional err_count output via macro CYC74_DEC_ERRCNT_EN. Rev 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

module cyc74_dec_sched (
   input  wire              clk,
   input  wire              rst,
   cyc74_dec_sched_if.slave bus,
   output logic             busy
`ifdef CYC74_DEC_ERRCNT_EN
   ,
   output logic [7:0]       err_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SYND = 2'd1,
      S_CORR = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   localparam logic [2:0] c_CNT_TOP   = 3'd6;
   localparam logic [2:0] c_SYN_MATCH = 3'b101;   // x^6 mod g(x) = x^2 + 1

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_cnt;
   logic [6:0] r_buf;
   logic [2:0] r_syn;
   logic       r_id;
   logic       r_err;
   logic       r_last;
   logic       w_grant;
   logic       w_accept;
   logic       w_fire;
   logic       w_e;
   logic       w_bit;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_fire   = 1'b0;
      w_grant  = (bus.in0_valid & bus.in1_valid) ? ~r_last : bus.in1_valid;
      case (r_state)
         S_IDLE: begin
            if (bus.in0_valid | bus.in1_valid) begin
               w_accept = 1'b1;
               w_next   = S_SYND;
            end
         end
         S_SYND: if (r_cnt == 3'd0) w_next = S_CORR;
         S_CORR: if (r_cnt == 3'd0) w_next = S_OUT;
         S_OUT: begin
            if (bus.out_ready) begin
               w_fire = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_bit = r_buf[r_cnt];
   assign w_e   = (r_syn == c_SYN_MATCH);

   // Datapath: r_syn = {s2,s1,s0}; SYND divides the word MSB-first by g(x)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= 3'd0;
         r_buf  <= 7'd0;
         r_syn  <= 3'd0;
         r_id   <= 1'b0;
         r_err  <= 1'b0;
         r_last <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_buf  <= w_grant ? bus.in1_code : bus.in0_code;
                  r_id   <= w_grant;
                  r_last <= w_grant;
                  r_syn  <= 3'd0;
                  r_err  <= 1'b0;
                  r_cnt  <= c_CNT_TOP;
               end
            end
            S_SYND: begin
               r_syn <= {r_syn[1], r_syn[0] ^ r_syn[2], w_bit ^ r_syn[2]};
               r_cnt <= (r_cnt == 3'd0) ? c_CNT_TOP : r_cnt - 3'd1;
            end
            S_CORR: begin
               r_buf[r_cnt] <= w_bit ^ w_e;
               if (w_e) begin
                  r_syn <= 3'd0;
                  r_err <= 1'b1;
               end else begin
                  r_syn <= {r_syn[1], r_syn[0] ^ r_syn[2], r_syn[2]};
               end
               r_cnt <= (r_cnt == 3'd0) ? 3'd0 : r_cnt - 3'd1;
            end
            default: ;
         endcase
      end
   end

   // Handshakes are suppressed while rst is high so none can complete
   assign bus.in0_ready = w_accept & ~w_grant & ~rst;
   assign bus.in1_ready = w_accept &  w_grant & ~rst;
   assign bus.out_valid = (r_state == S_OUT) & ~rst;
   assign bus.out_code  = r_buf;
   assign bus.out_data  = r_buf[6:3];
   assign bus.out_id    = r_id;
   assign bus.out_err   = r_err;
   assign busy          = (r_state != S_IDLE);

`ifdef CYC74_DEC_ERRCNT_EN
   logic [7:0] r_err_count;

   always_ff @(posedge clk) begin
      if (rst)
         r_err_count <= 8'd0;
      else if (w_fire && r_err && (r_err_count != 8'hFF))
         r_err_count <= r_err_count + 8'd1;
   end

   assign err_count = r_err_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cyc74_dec_sched.sv
// Self-checking bench for cyc74_dec_sched against a codebook-search decoder model.
`default_nettype none

module tb_cyc74_dec_sched;
   logic clk;
   logic rst;
   logic busy;
`ifdef CYC74_DEC_ERRCNT_EN
   logic [7:0] err_count;
`endif
   int n_total = 0;
   int n_bad   = 0;

   cyc74_dec_sched_if bus ();

   cyc74_dec_sched dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
`ifdef CYC74_DEC_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Systematic encoding: c(x) = m(x)x^3 + (m(x)x^3 mod g(x)), by long division
   function automatic logic [6:0] encode(input logic [3:0] m);
      logic [6:0] r;
      r = {m, 3'b000};
      for (int i = 6; i >= 3; i--)
         if (r[i]) r = r ^ (7'b0001011 << (i - 3));
      return {m, r[2:0]};
   endfunction

   // Nearest codeword within distance 1, found by searching the whole codebook
   function automatic void model_decode(input logic [6:0] rx, output logic [6:0] exp_code,
                                        output logic exp_err, output logic known);
      logic [6:0] c;
      exp_code = 7'd0;
      exp_err  = 1'b0;
      known    = 1'b0;
      for (int m = 0; m < 16; m++) begin
         c = encode(4'(m));
         if ($countones(c ^ rx) <= 1) begin
            exp_code = c;
            exp_err  = ($countones(c ^ rx) == 1);
            known    = 1'b1;
         end
      end
   endfunction

   // Offers one word on a requester, waits for the result and takes it (out_ready high).
   task automatic run_word(input logic id, input logic [6:0] code, output int lat,
                           output logic [6:0] oc, output logic [3:0] od,
                           output logic oid, output logic oerr);
      int k;
      lat = -1; oc = 7'd0; od = 4'd0; oid = 1'b0; oerr = 1'b0;
      if (id) begin bus.in1_valid = 1'b1; bus.in1_code = code; end
      else    begin bus.in0_valid = 1'b1; bus.in0_code = code; end
      #1;
      k = 0;
      while (!(id ? bus.in1_ready : bus.in0_ready) && k < 40) begin
         @(posedge clk); #1; k++;
      end
      if (k >= 40) begin
         bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
      k = 1;
      while (!bus.out_valid && k < 40) begin
         @(posedge clk); #1; k++;
      end
      if (bus.out_valid) begin
         lat = k; oc = bus.out_code; od = bus.out_data; oid = bus.out_id; oerr = bus.out_err;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in0_valid = 1'b0; bus.in1_valid = 1'b0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
      bus.in0_code = 7'h55; bus.in1_code = 7'h2A;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_ready: got %b want 00", {bus.in0_ready, bus.in1_ready});
      end
      bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_total++;
      if ({bus.out_valid, bus.out_code, bus.out_data, bus.out_id, bus.out_err, busy,
           bus.in0_ready, bus.in1_ready} !== 17'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: valid=%b code=%b data=%b id=%b err=%b busy=%b want all 0",
                  bus.out_valid, bus.out_code, bus.out_data, bus.out_id, bus.out_err, busy);
      end
   endtask

   task automatic test_clean();
      int lat; logic [6:0] oc; logic [3:0] od; logic oid, oerr;
      run_word(1'b0, 7'b0001011, lat, oc, od, oid, oerr);
      n_total++;
      if (lat !== 15 || oc !== 7'b0001011 || od !== 4'b0001 || oid !== 1'b0 || oerr !== 1'b0) begin
         n_bad++;
         $display("FAIL clean_word: lat=%0d code=%b data=%b id=%b err=%b want 15 0001011 0001 0 0",
                  lat, oc, od, oid, oerr);
      end
   endtask

   task automatic test_sweep();
      int lat; logic [6:0] oc; logic [3:0] od; logic oid, oerr, id;
      logic [6:0] c, rx;
      for (int m = 0; m < 16; m++) begin
         for (int p = 0; p < 7; p++) begin
            c  = encode(4'(m));
            rx = c ^ (7'b0000001 << p);
            id = 1'($urandom_range(0, 1));
            run_word(id, rx, lat, oc, od, oid, oerr);
            n_total++;
            if (oc !== c || od !== c[6:3] || oerr !== 1'b1) begin
               n_bad++;
               $display("FAIL sweep_fix rx=%b: code=%b data=%b err=%b want %b %b 1",
                        rx, oc, od, oerr, c, c[6:3]);
            end
            n_total++;
            if (lat !== 15 || oid !== id) begin
               n_bad++;
               $display("FAIL sweep_lat_id rx=%b: lat=%0d id=%b want 15 %b", rx, lat, oid, id);
            end
         end
      end
   endtask

   task automatic test_contention();
      logic [6:0] a, b, ea, eb, codes[3];
      logic ids[3], ke;
      int k;
      do_reset();
      a = encode(4'd5) ^ 7'b0100000;
      b = encode(4'd10);
      model_decode(a, ea, ke, ke);
      model_decode(b, eb, ke, ke);
      bus.in0_code = a; bus.in1_code = b;
      bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         k = 0;
         while (!bus.out_valid && k < 40) begin @(posedge clk); #1; k++; end
         ids[i] = bus.out_valid ? bus.out_id : 1'bx;
         codes[i] = bus.out_code;
         @(posedge clk); #1;
      end
      bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
      n_total++;
      if (ids[0] !== 1'b0 || ids[1] !== 1'b1 || ids[2] !== 1'b0) begin
         n_bad++;
         $display("FAIL contention_ids: got %b%b%b want 010", ids[0], ids[1], ids[2]);
      end
      n_total++;
      if (codes[0] !== ea || codes[1] !== eb || codes[2] !== ea) begin
         n_bad++;
         $display("FAIL contention_codes: got %b %b %b want %b %b %b",
                  codes[0], codes[1], codes[2], ea, eb, ea);
      end
      #1;
      n_total++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL contention_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_backpressure();
      logic [6:0] w, snap_c;
      logic [3:0] snap_d;
      logic snap_id, snap_err, broken;
      int k;
      w = encode(4'd9) ^ 7'b0000100;
      bus.out_ready = 1'b0;
      bus.in0_valid = 1'b1; bus.in0_code = w;
      #1;
      k = 0;
      while (!bus.in0_ready && k < 40) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      bus.in0_valid = 1'b0;
      bus.in1_valid = 1'b1; bus.in1_code = encode(4'd3);
      k = 1;
      while (!bus.out_valid && k < 40) begin @(posedge clk); #1; k++; end
      snap_c = bus.out_code; snap_d = bus.out_data; snap_id = bus.out_id; snap_err = bus.out_err;
      n_total++;
      if (k !== 15 || snap_c !== encode(4'd9) || snap_err !== 1'b1 || snap_id !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_result: lat=%0d code=%b err=%b id=%b want 15 %b 1 0",
                  k, snap_c, snap_err, snap_id, encode(4'd9));
      end
      broken = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (!bus.out_valid || bus.out_code !== snap_c || bus.out_data !== snap_d ||
             bus.out_id !== snap_id || bus.out_err !== snap_err ||
             bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0 || busy !== 1'b1)
            broken = 1'b1;
      end
      n_total++;
      if (broken !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_stall: unstable=%b want 0", broken);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in1_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_release: valid=%b busy=%b in1_ready=%b want 0 0 1",
                  bus.out_valid, busy, bus.in1_ready);
      end
      bus.in1_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset_mid();
      logic [6:0] w1, w2;
      int k;
      w1 = encode(4'd12) ^ 7'b0001000;
      w2 = encode(4'd6) ^ 7'b1000000;
      bus.in0_valid = 1'b1; bus.in0_code = w1;
      #1;
      k = 0;
      while (!bus.in0_ready && k < 40) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      bus.in0_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.in0_valid = 1'b1; bus.in0_code = w2;
      #1;
      n_total++;
      if (bus.in0_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_ready_in_rst: in0_ready=%b want 0", bus.in0_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_total++;
      if ({bus.out_valid, bus.out_code, bus.out_data, bus.out_id, bus.out_err, busy} !== 15'd0) begin
         n_bad++;
         $display("FAIL rstmid_outputs: valid=%b code=%b data=%b id=%b err=%b busy=%b want all 0",
                  bus.out_valid, bus.out_code, bus.out_data, bus.out_id, bus.out_err, busy);
      end
      n_total++;
      if (bus.in0_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_accept: in0_ready=%b want 1", bus.in0_ready);
      end
      @(posedge clk); #1;
      bus.in0_valid = 1'b0;
      k = 1;
      while (!bus.out_valid && k < 40) begin @(posedge clk); #1; k++; end
      n_total++;
      if (k !== 15 || bus.out_code !== encode(4'd6) || bus.out_err !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_newword: lat=%0d code=%b err=%b want 15 %b 1",
                  k, bus.out_code, bus.out_err, encode(4'd6));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int lat, ne, p1, p2;
      logic [6:0] rx, ec, oc;
      logic [3:0] od;
      logic oid, oerr, ee, known, id;
      for (int i = 0; i < 40; i++) begin
         ne = $urandom_range(0, 2);
         rx = encode(4'($urandom_range(0, 15)));
         p1 = $urandom_range(0, 6);
         p2 = (p1 + $urandom_range(1, 6)) % 7;
         if (ne >= 1) rx[p1] = ~rx[p1];
         if (ne == 2) rx[p2] = ~rx[p2];
         id = 1'($urandom_range(0, 1));
         model_decode(rx, ec, ee, known);
         run_word(id, rx, lat, oc, od, oid, oerr);
         n_total++;
         if (lat !== 15 || oid !== id) begin
            n_bad++;
            $display("FAIL random_lat rx=%b errs=%0d: lat=%0d id=%b want 15 %b", rx, ne, lat, oid, id);
         end
         if (known) begin
            n_total++;
            if (oc !== ec || oerr !== ee || od !== ec[6:3]) begin
               n_bad++;
               $display("FAIL random_fix rx=%b: code=%b err=%b data=%b want %b %b %b",
                        rx, oc, oerr, od, ec, ee, ec[6:3]);
            end
         end
      end
   endtask

`ifdef CYC74_DEC_ERRCNT_EN
   task automatic test_errcnt();
      int lat; logic [6:0] oc, c; logic [3:0] od; logic oid, oerr;
      do_reset();
      n_total++;
      if (err_count !== 8'd0) begin
         n_bad++;
         $display("FAIL errcnt_reset: got %0d want 0", err_count);
      end
      for (int i = 0; i < 300; i++) begin
         c = encode(4'($urandom_range(0, 15)));
         run_word(1'($urandom_range(0, 1)), c ^ (7'b0000001 << $urandom_range(0, 6)),
                  lat, oc, od, oid, oerr);
         if (i == 9) begin
            n_total++;
            if (err_count !== 8'd10) begin
               n_bad++;
               $display("FAIL errcnt_10: got %0d want 10", err_count);
            end
         end
      end
      n_total++;
      if (err_count !== 8'd255) begin
         n_bad++;
         $display("FAIL errcnt_sat: got %0d want 255", err_count);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
      bus.in0_code = 7'd0; bus.in1_code = 7'd0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_clean();
      test_sweep();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_random();
`ifdef CYC74_DEC_ERRCNT_EN
      test_errcnt();
`endif
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cyc74_dec_sched.md
# cyc74_dec_sched

Scheduler and sequencer for the bit-serial (7,4) cyclic-code decoder engine (generator g(x)=x^3+x+1, Meggitt-style syndrome shift register). Two upstream requesters share one engine through round-robin arbitration. Each accepted codeword is sequenced through a 7-cycle syndrome phase and a 7-cycle correction phase. The corrected word is presented on a valid/ready output port tagged with the source requester. The block sits between the channel-side word framers and the data sink.

## Interface
Parameters:
- none (code length 7, message length 4 fixed)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- in0_valid  in  1  requester 0 has a codeword
- in0_code  in  7  requester 0 codeword, bit 6 = highest-order term
- in0_ready  out  1  requester 0 codeword accepted this cycle (valid & ready)
- in1_valid / in1_code / in1_ready  same as above, requester 1
- out_valid  out  1  corrected result held
- out_ready  in  1  sink accepts result
- out_code  out  7  corrected codeword
- out_data  out  4  message bits = out_code[6:3] (systematic)
- out_id  out  1  requester that supplied the word
- out_err  out  1  one bit was corrected
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, SYND, CORR, OUT.
- IDLE:
  - If any inX_valid, grant one requester, latch its code into buffer, record id, clear syndrome regs s0..s2, go to SYND.
  - inX_ready is asserted only for the granted requester, combinationally, in IDLE only.
- Arbitration: round-robin with 1-bit last-granted pointer.
  - Both valid: grant the requester not last granted.
  - Single valid: grant it.
  - Pointer updates on every grant.
  - After reset, pointer = 1, so requester 0 wins the first tie.
- SYND: 7 cycles, phase counter 6 down to 0.
  - Each cycle shifts buffer[cnt] into the dividing register (feedback taps per g(x)).
  - At cnt=0, go to CORR with cnt=6.
- CORR: 7 cycles, cnt 6 down to 0.
  - Each cycle evaluates the Meggitt pattern detector e on the syndrome register.
  - Writes corrected bit = buffer[cnt] ^ e, then shifts the register with zero input, feeding back e.
  - On e=1, clear the register and set the err flag.
  - At cnt=0, go to OUT.
- OUT: out_valid=1 and out_* held stable until out_ready. On out_valid & out_ready, go to IDLE.
- Functional requirement: for every codeword of the code with 0 or 1 flipped bit, out_code equals the original codeword, and out_err = (one bit flipped).
- Double errors: result unspecified but the sequence must still complete in 14 cycles.
- Reset: any state goes to IDLE. out_valid=0, out_code=0, out_data=0, out_id=0, out_err=0, busy=0, in0_ready=in1_ready=0. Pointer=1, in-flight word discarded.

## Timing
- Accept edge = cycle 0 (inX_valid & inX_ready sampled high).
- SYND occupies cycles 1..7 and CORR cycles 8..14.
- out_valid is first high in cycle 15, after the edge ending CORR.
- Fixed latency 15 cycles accept-to-valid; no variable component.
- Throughput: at most one word per 16 cycles with out_ready held high.
  - The OUT handshake cycle returns to IDLE.
  - The next accept happens no earlier than the following cycle.
- No accept while busy; inX_valid held by a requester is not dropped, only delayed.
- out_ready low stalls in OUT indefinitely, with outputs stable.
- rst has priority over every transition, including a handshake in the same cycle; the handshake does not occur.

## Configuration
- Macro CYC74_DEC_ERRCNT_EN.
- Defined: adds output err_count (8 bits).
  - Increments by 1 on each OUT handshake with out_err=1.
  - Saturates at 255 and clears on rst.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Clean word, requester 0: in0_code=7'b0001011, out_ready=1 -> out_valid at cycle 15, out_code=7'b0001011, out_data=4'b0001, out_err=0, out_id=0.
- Single-bit error sweep: each of the 16 codewords with each of the 7 bit positions flipped -> out_code = original word, out_err=1 for all 112 cases.
- Contention: both valid from reset -> requester 0 served first, requester 1 second, requester 0 third; out_id sequence 0,1,0; no word lost.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> outputs stable, in0_ready/in1_ready stay 0. On out_ready=1, one handshake, then IDLE.
- Reset mid-CORR: rst at cycle 10 -> next cycle all outputs 0, busy=0. The aborted word is never emitted, and a new word is accepted immediately after.
- With CYC74_DEC_ERRCNT_EN: 300 single-error words -> err_count=255.
